silife_spi_loader: RTL

SPI-slave pattern loader and generation sequencer for the 8x32 SiLife grid. It receives serial command frames from an external host and converts them into grid write cycles (row select plus set/clear masks) and generation-step control. It sits directly upstream of the grid write and enable inputs, replacing manual switch-driven loading. Its set/clear masks are zero whenever no write is active, so they can be ORed or muxed straight into the grid.

---
 rtl/silife_spi_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/silife_spi_loader.sv
// silife_spi_loader: SPI-slave (mode 0, MSB first) pattern loader and
// generation sequencer for the SiLife grid.
//
// A frame starts when chip select falls. Its first byte is a command:
// bits [7:5] hold the opcode and bits [4:0] hold an argument. The loader
// turns commands into grid row writes and generation steps.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   i_spi_cs_n       SPI chip select, active low (asynchronous to clk)
//   i_spi_sck        SPI clock, mode 0 (asynchronous to clk)
//   i_spi_mosi       SPI data, MSB first (asynchronous to clk)
//   o_row_select     grid row written while o_wr is high
//   o_set_cells      cells to set, zero when o_wr is low
//   o_clear_cells    cells to clear, zero when o_wr is low
//   o_wr             one-cycle grid write strobe
//   o_step           grid enable, one generation per high cycle
//   o_run            free-run level
//   o_busy           CLEAR or STEP sequence in progress
module silife_spi_loader #(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 32,
  parameter int ROW_BITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_spi_cs_n,
  input  logic                  i_spi_sck,
  input  logic                  i_spi_mosi,
  output logic [ROW_BITS-1:0]   o_row_select,
  output logic [GRID_WIDTH-1:0] o_set_cells,
  output logic [GRID_WIDTH-1:0] o_clear_cells,
  output logic                  o_wr,
  output logic                  o_step,
  output logic                  o_run,
  output logic                  o_busy
);

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_OR    = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
  localparam logic [2:0] OP_STEP  = 3'b100;
  localparam logic [2:0] OP_RUN   = 3'b101;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(GRID_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DATA, S_CLEAR, S_STEP, S_DISCARD
  } state_t;

  state_t              state;
  logic [1:0]          cs_sync;
  logic                cs_d;
  logic [2:0]          sck_sync;
  logic [1:0]          mosi_sync;
  logic [2:0]          bit_cnt;
  logic [6:0]          shreg;
  logic [ROW_BITS-1:0] ptr;
  logic                or_mode;
  logic [4:0]          cnt;

  logic       cs_n, cs_fall, sample, byte_done;
  logic [7:0] rx_byte;

  // The chip-select chain resets to 0 so that a select already low when
  // reset releases never looks like a falling edge: only a real high-to-low
  // transition after reset starts a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '0;
      cs_d      <= 1'b0;
      sck_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[0], i_spi_cs_n};
      cs_d      <= cs_sync[1];
      sck_sync  <= {sck_sync[1:0], i_spi_sck};
      mosi_sync <= {mosi_sync[0], i_spi_mosi};
    end
  end

  assign cs_n      = cs_sync[1];
  assign cs_fall   = cs_d & ~cs_n;
  assign sample    = sck_sync[1] & ~sck_sync[2] & ~cs_n;
  assign rx_byte   = {shreg, mosi_sync[1]};
  assign byte_done = sample && (bit_cnt == 3'd7);

  // A partial byte is dropped simply because deselect clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (cs_n) begin
      bit_cnt <= '0;
    end else if (sample) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= rx_byte[6:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      o_row_select  <= '0;
      o_set_cells   <= '0;
      o_clear_cells <= '0;
      o_wr          <= 1'b0;
      o_step        <= 1'b0;
      o_run         <= 1'b0;
      ptr           <= '0;
      or_mode       <= 1'b0;
      cnt           <= '0;
    end else begin
      // Strobes and masks are single-cycle unless a state re-asserts them.
      o_wr          <= 1'b0;
      o_step        <= 1'b0;
      o_set_cells   <= '0;
      o_clear_cells <= '0;
      case (state)
        S_IDLE: if (cs_fall) state <= S_CMD;
        S_CMD: begin
          if (cs_n) state <= S_IDLE;
          else if (byte_done) begin
            case (rx_byte[7:5])
              OP_LOAD, OP_OR: begin
                state   <= S_DATA;
                ptr     <= ROW_BITS'(rx_byte[4:0]);
                or_mode <= (rx_byte[7:5] == OP_OR);
              end
              OP_CLEAR: begin
                state         <= S_CLEAR;
                o_wr          <= 1'b1;
                o_row_select  <= '0;
                o_clear_cells <= '1;
              end
              OP_STEP: begin
                state  <= S_STEP;
                o_step <= 1'b1;
                cnt    <= rx_byte[4:0];
              end
              OP_RUN: begin
                o_run <= rx_byte[0];
                state <= S_DISCARD;
              end
              default: state <= S_DISCARD;
            endcase
          end
        end
        S_DATA: begin
          if (cs_n) state <= S_IDLE;
          else if (byte_done) begin
            o_wr          <= 1'b1;
            o_row_select  <= ptr;
            o_set_cells   <= GRID_WIDTH'(rx_byte);
            o_clear_cells <= or_mode ? '0 : ~(GRID_WIDTH'(rx_byte));
            ptr           <= (ptr == LAST_ROW) ? '0 : ptr + 1'b1;
          end
        end
        // o_row_select doubles as the sweep counter; the write to the last
        // row is already on the outputs when the sweep ends.
        S_CLEAR: begin
          if (o_row_select == LAST_ROW) state <= cs_n ? S_IDLE : S_DISCARD;
          else begin
            o_wr          <= 1'b1;
            o_row_select  <= o_row_select + 1'b1;
            o_clear_cells <= '1;
          end
        end
        // cnt holds the number of step cycles still to come after this one.
        S_STEP: begin
          if (cnt == 5'd0) state <= cs_n ? S_IDLE : S_DISCARD;
          else begin
            cnt    <= cnt - 5'd1;
            o_step <= 1'b1;
          end
        end
        S_DISCARD: if (cs_n) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (state == S_CLEAR) || (state == S_STEP);

endmodule
